// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: memory read port, decoder port, execute handoff and branch redirect.
interface fetch_if;
  localparam int unsigned XLEN = 16;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            dec_en;
  logic [XLEN-1:0] dec_instr;
  logic            dec_next_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            branch_en;
  logic [XLEN-1:0] branch_target;

  // Fetch unit side
  modport master (
    output mem_req, mem_addr, dec_en, dec_instr, out_valid, out_imm, out_pc,
    input  mem_ack, mem_rdata, dec_next_word, out_ready, branch_en, branch_target
  );

  // Memory / decoder / execute side
  modport slave (
    input  mem_req, mem_addr, dec_en, dec_instr, out_valid, out_imm, out_pc,
    output mem_ack, mem_rdata, dec_next_word, out_ready, branch_en, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches one or two 16-bit words per instruction, pulses the
// decoder once per instruction, hands (pc, imm) to execute and applies branch redirects.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);
  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(2);

  typedef enum logic [2:0] {FETCH1, DEC, WAITNW, FETCH2, ISSUE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            redirect_pend_q, redirect_pend_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            dec_en_q, dec_en_d;
  logic [XLEN-1:0] dec_instr_q, dec_instr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] br_target;

  assign br_target     = bus.branch_target & ~XLEN'(1);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.dec_en    = dec_en_q;
  assign bus.dec_instr = dec_instr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_pc    = out_pc_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FETCH1;
      pc_q            <= RESET_PC;
      target_q        <= RESET_PC;
      redirect_pend_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= RESET_PC;
      dec_en_q        <= 1'b0;
      dec_instr_q     <= '0;
      out_valid_q     <= 1'b0;
      out_imm_q       <= '0;
      out_pc_q        <= RESET_PC;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      target_q        <= target_d;
      redirect_pend_q <= redirect_pend_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      dec_en_q        <= dec_en_d;
      dec_instr_q     <= dec_instr_d;
      out_valid_q     <= out_valid_d;
      out_imm_q       <= out_imm_d;
      out_pc_q        <= out_pc_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they register on entry
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    target_d        = target_q;
    redirect_pend_d = redirect_pend_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    dec_en_d        = 1'b0;
    dec_instr_d     = dec_instr_q;
    out_valid_d     = 1'b0;
    out_imm_d       = out_imm_q;
    out_pc_d        = out_pc_q;

    if (mem_req_q) begin
      // A request is outstanding; it always runs to its ack, even across a branch
      if (bus.mem_ack) begin
        mem_req_d = 1'b0;
        if (bus.branch_en || redirect_pend_q) begin
          // Discard the returned word and restart at the newest target
          pc_d            = bus.branch_en ? br_target : target_q;
          redirect_pend_d = 1'b0;
          state_d         = FETCH1;
          mem_req_d       = 1'b1;
          mem_addr_d      = pc_d;
        end else if (state_q == FETCH1) begin
          dec_instr_d = bus.mem_rdata;
          dec_en_d    = 1'b1;
          pc_d        = pc_q + WORD_STEP;
          state_d     = DEC;
        end else begin
          out_imm_d   = bus.mem_rdata;
          pc_d        = pc_q + WORD_STEP;
          out_pc_d    = pc_d;
          out_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end else if (bus.branch_en) begin
        redirect_pend_d = 1'b1;
        target_d        = br_target;
      end
    end else if (bus.branch_en) begin
      // Nothing in flight: redirect at once (an ISSUE transfer in this cycle still counts)
      pc_d       = br_target;
      state_d    = FETCH1;
      mem_req_d  = 1'b1;
      mem_addr_d = br_target;
    end else begin
      case (state_q)
        FETCH1, FETCH2: begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        DEC: state_d = WAITNW;
        WAITNW: begin
          if (bus.dec_next_word) begin
            state_d    = FETCH2;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else begin
            out_imm_d   = '0;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            state_d    = FETCH1;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: state_d = FETCH1;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory, decoder and execute models around the DUT,
// with expected (pc, imm) handoffs queued per test and compared on each transfer.
module tb_fetch_unit;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  exp_t        e_pop;
  logic [15:0] acks[$];
  logic [15:0] decs[$];
  logic [15:0] mem_m [logic [15:0]];
  int          wait_states = 0;
  int          wcnt = 0;
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  int          cyc = 0;
  int          t_req = -1;
  int          t_dec = -1;
  int          t_valid = -1;
  logic        prev_req = 1'b0;
  logic        prev_dec = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] hold_pc = '0;
  logic [15:0] hold_imm = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 16'h0101;
  endfunction

  task automatic check_ack(input string tag, input int i, input logic [15:0] exp);
    check(tag, (acks.size() > i) ? 32'(acks[i]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_dec(input string tag, input int i, input logic [15:0] exp);
    check(tag, (decs.size() > i) ? 32'(decs[i]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  // Memory, decoder and execute models plus per-cycle protocol checks
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bus.mem_ack       = 1'b0;
      bus.mem_rdata     = '0;
      bus.dec_next_word = 1'b0;
      bus.out_ready     = 1'b0;
      wcnt      = 0;
      stall_cnt = 0;
      prev_req  = 1'b0;
      prev_dec  = 1'b0;
    end else begin
      if (prev_req && !bus.mem_ack) begin
        check("req_hold", 32'(bus.mem_req), 32'd1);
        check("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
      end
      if (bus.mem_req && t_req < 0) t_req = cyc;
      if (!bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else begin
        if (bus.mem_ack) wcnt = 0;
        if (wcnt >= wait_states) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          acks.push_back(bus.mem_addr);
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end
      prev_req  = bus.mem_req;
      prev_addr = bus.mem_addr;

      // Decoder: two-word instructions have bit 15 set
      bus.dec_next_word = prev_dec ? bus.dec_instr[15] : 1'b0;
      if (bus.dec_en) begin
        check("dec_pulse", 32'(prev_dec), 32'd0);
        decs.push_back(bus.dec_instr);
        if (t_dec < 0) t_dec = cyc;
      end
      prev_dec = bus.dec_en;

      // Execute: accept only expected handoffs, optionally after a stall
      bus.out_ready = 1'b0;
      if (bus.out_valid) begin
        if (t_valid < 0) t_valid = cyc;
        check("valid_noreq", 32'(bus.mem_req), 32'd0);
        if (exp_q.size() > 0) begin
          if (stall_cnt == 0) begin
            hold_pc  = bus.out_pc;
            hold_imm = bus.out_imm;
          end else begin
            check("hold_pc", 32'(bus.out_pc), 32'(hold_pc));
            check("hold_imm", 32'(bus.out_imm), 32'(hold_imm));
          end
          if (stall_cnt >= stall_cycles) begin
            e_pop = exp_q.pop_front();
            check("out_pc", 32'(bus.out_pc), 32'(e_pop.pc));
            check("out_imm", 32'(bus.out_imm), 32'(e_pop.imm));
            bus.out_ready = 1'b1;
            stall_cnt = 0;
          end else begin
            stall_cnt++;
          end
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    bus.branch_en     = 1'b0;
    bus.branch_target = '0;
    exp_q.delete();
    acks.delete();
    decs.delete();
    mem_m.delete();
    stall_cycles = 0;
    wait_states  = 0;
    t_req   = -1;
    t_dec   = -1;
    t_valid = -1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
    check("rst_dec_en", 32'(bus.dec_en), 32'd0);
    check("rst_dec_instr", 32'(bus.dec_instr), 32'h0000);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_imm", 32'(bus.out_imm), 32'h0000);
    check("rst_out_pc", 32'(bus.out_pc), 32'h0000);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.mem_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, 32'(bus.mem_req), 32'd1);
  endtask

  initial begin
    // One-word instruction, zero-wait memory
    reset_dut();
    mem_m[16'h0000] = 16'h0312;
    exp_q.push_back('{pc: 16'h0002, imm: 16'h0000});
    rst = 1'b0;
    drain("t1");
    check("t1_dec_lat", 32'(t_dec - t_req), 32'd1);
    check("t1_valid_lat", 32'(t_valid - t_req), 32'd3);
    check_ack("t1_ack0", 0, 16'h0000);
    check_dec("t1_dec0", 0, 16'h0312);

    // Two-word instruction, execute stalls 5 cycles in ISSUE
    reset_dut();
    mem_m[16'h0000] = 16'h8312;
    mem_m[16'h0002] = 16'hBEEF;
    stall_cycles = 5;
    exp_q.push_back('{pc: 16'h0004, imm: 16'hBEEF});
    rst = 1'b0;
    drain("t2");
    check("t2_valid_lat", 32'(t_valid - t_req), 32'd4);
    check_ack("t2_ack0", 0, 16'h0000);
    check_ack("t2_ack1", 1, 16'h0002);
    check("t2_dec_n", 32'(decs.size()), 32'd1);
    check_dec("t2_dec0", 0, 16'h8312);

    // Branch during a FETCH1 with 3 wait states: word discarded, refetch at 0x1234
    reset_dut();
    wait_states = 3;
    mem_m[16'h0000] = 16'h0312;
    mem_m[16'h1234] = 16'h0456;
    exp_q.push_back('{pc: 16'h1236, imm: 16'h0000});
    rst = 1'b0;
    wait_req("t4");
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h1235;
    @(negedge clk);
    bus.branch_en = 1'b0;
    drain("t4");
    check_ack("t4_ack0", 0, 16'h0000);
    check_ack("t4_ack1", 1, 16'h1234);
    check("t4_dec_n", 32'(decs.size()), 32'd1);
    check_dec("t4_dec0", 0, 16'h0456);

    // Second branch while a redirect is pending replaces the target
    reset_dut();
    wait_states = 3;
    mem_m[16'h3000] = 16'h0222;
    exp_q.push_back('{pc: 16'h3002, imm: 16'h0000});
    rst = 1'b0;
    wait_req("t7");
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h2000;
    @(negedge clk);
    bus.branch_en = 1'b0;
    @(negedge clk);
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'h3001;
    @(negedge clk);
    bus.branch_en = 1'b0;
    drain("t7");
    check_ack("t7_ack1", 1, 16'h3000);
    check_dec("t7_dec0", 0, 16'h0222);

    // PC wrap: branch from ISSUE to 0xFFFE, then a one-word instruction
    reset_dut();
    mem_m[16'h0000] = 16'h0312;
    mem_m[16'hFFFE] = 16'h0777;
    exp_q.push_back('{pc: 16'h0002, imm: 16'h0000});
    rst = 1'b0;
    drain("t5a");
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_issue_seen", 32'(bus.out_valid), 32'd1);
    acks.delete();
    bus.branch_en     = 1'b1;
    bus.branch_target = 16'hFFFF;
    @(negedge clk);
    bus.branch_en = 1'b0;
    check("t5_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t5_addr", 32'(bus.mem_addr), 32'h0000_FFFE);
    exp_q.push_back('{pc: 16'h0000, imm: 16'h0000});
    drain("t5b");
    begin
      int n = 0;
      while (acks.size() < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check_ack("t5_ack0", 0, 16'hFFFE);
    check_ack("t5_ack1", 1, 16'h0000);

    // Reset while a FETCH2 request is outstanding
    reset_dut();
    wait_states = 4;
    mem_m[16'h0000] = 16'h8312;
    rst = 1'b0;
    begin
      int n = 0;
      while (!(bus.mem_req && bus.mem_addr == 16'h0002) && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_in_fetch2", 32'(bus.mem_req && bus.mem_addr == 16'h0002), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_drop", 32'(bus.mem_req), 32'd0);
    check("t6_valid", 32'(bus.out_valid), 32'd0);
    check("t6_addr", 32'(bus.mem_addr), 32'h0000);
    reset_dut();
    mem_m[16'h0000] = 16'h0312;
    exp_q.push_back('{pc: 16'h0002, imm: 16'h0000});
    rst = 1'b0;
    drain("t6");
    check_ack("t6_ack0", 0, 16'h0000);
    check_dec("t6_dec0", 0, 16'h0312);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end
endmodule
